// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// master: datapath/IR side, slave: controller side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       i_operand;
  logic [2:0]       i_funct3;
  logic             i_funct7bit5;
  logic             i_zeroFlag;
  logic             i_memReady;
  logic             o_pcWriteEn;
  logic             o_adrSel;
  logic             o_irWriteEn;
  logic             o_memWriteEn;
  logic             o_regWriteEn;
  logic [1:0]       o_aluSrcA;
  logic [1:0]       o_aluSrcB;
  logic [1:0]       o_resultSel;
  logic [3:0]       o_aluLogicOperation;
  logic             o_illegal;
  logic [CNT_W-1:0] o_retiredCount;

  modport master (
    output i_operand, i_funct3, i_funct7bit5,
    output i_zeroFlag, i_memReady,
    input  o_pcWriteEn, o_adrSel, o_irWriteEn,
    input  o_memWriteEn, o_regWriteEn,
    input  o_aluSrcA, o_aluSrcB, o_resultSel,
    input  o_aluLogicOperation, o_illegal,
    input  o_retiredCount
  );

  modport slave (
    input  i_operand, i_funct3, i_funct7bit5,
    input  i_zeroFlag, i_memReady,
    output o_pcWriteEn, o_adrSel, o_irWriteEn,
    output o_memWriteEn, o_regWriteEn,
    output o_aluSrcA, o_aluSrcB, o_resultSel,
    output o_aluLogicOperation, o_illegal,
    output o_retiredCount
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute over one ALU
// and one memory. Ports: i_clk, i_rst (sync high), bus (slave modport).
module multicycle_controller #(
  parameter bit EN_IALU = 1'b1,
  parameter bit EN_JAL  = 1'b1,
  parameter bit EN_BNE  = 1'b1,
  parameter int CNT_W   = 32
) (
  input logic i_clk,
  input logic i_rst,
  multicycle_controller_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t           state;
  state_t           nextState;
  state_t           decodeTarget;
  logic             retire;
  logic             brLegal;
  logic             illegalQ;
  logic [CNT_W-1:0] count;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_FETCH;
      count    <= '0;
      illegalQ <= 1'b0;
    end else begin
      state <= nextState;
      if (retire) count <= count + CNT_ONE;
      if (nextState == S_TRAP) illegalQ <= 1'b1;
    end
  end

  // BEQ always legal; BNE only when enabled.
  assign brLegal = (bus.i_funct3 == 3'b000) ||
                   (EN_BNE && bus.i_funct3 == 3'b001);

  always_comb begin
    decodeTarget = S_TRAP;
    unique case (1'b1)
      bus.i_operand == OP_LOAD:  decodeTarget = S_MEMADR;
      bus.i_operand == OP_STORE: decodeTarget = S_MEMADR;
      bus.i_operand == OP_R:     decodeTarget = S_EXECR;
      bus.i_operand == OP_I:
        decodeTarget = EN_IALU ? S_EXECI : S_TRAP;
      bus.i_operand == OP_BR:
        decodeTarget = brLegal ? S_BRANCH : S_TRAP;
      bus.i_operand == OP_JAL:
        decodeTarget = EN_JAL ? S_JAL : S_TRAP;
      default: decodeTarget = S_TRAP;
    endcase
  end

  always_comb begin
    nextState               = state;
    retire                  = 1'b0;
    bus.o_pcWriteEn         = 1'b0;
    bus.o_adrSel            = 1'b0;
    bus.o_irWriteEn         = 1'b0;
    bus.o_memWriteEn        = 1'b0;
    bus.o_regWriteEn        = 1'b0;
    bus.o_aluSrcA           = 2'b00;
    bus.o_aluSrcB           = 2'b00;
    bus.o_resultSel         = 2'b00;
    bus.o_aluLogicOperation = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        bus.o_aluSrcB   = 2'b10;
        bus.o_resultSel = 2'b10;
        bus.o_irWriteEn = bus.i_memReady;
        bus.o_pcWriteEn = bus.i_memReady;
        if (bus.i_memReady) nextState = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        bus.o_aluSrcA = 2'b01;
        bus.o_aluSrcB = 2'b01;
        nextState     = decodeTarget;
      end
      S_MEMADR: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluSrcB = 2'b01;
        nextState = (bus.i_operand == OP_LOAD) ? S_MEMREAD
                                               : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.o_adrSel = 1'b1;
        if (bus.i_memReady) nextState = S_MEMWB;
      end
      S_MEMWB: begin
        bus.o_resultSel  = 2'b01;
        bus.o_regWriteEn = 1'b1;
        retire           = 1'b1;
        nextState        = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.o_adrSel     = 1'b1;
        bus.o_memWriteEn = 1'b1;
        if (bus.i_memReady) begin
          retire    = 1'b1;
          nextState = S_FETCH;
        end
      end
      S_EXECR: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluLogicOperation =
          {bus.i_funct7bit5, bus.i_funct3};
        nextState = S_ALUWB;
      end
      S_EXECI: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluSrcB = 2'b01;
        // Bit 30 only selects SRAI vs SRLI; elsewhere it is immediate.
        if (bus.i_funct3 == 3'b101)
          bus.o_aluLogicOperation =
            {bus.i_funct7bit5, bus.i_funct3};
        else
          bus.o_aluLogicOperation = {1'b0, bus.i_funct3};
        nextState = S_ALUWB;
      end
      S_ALUWB: begin
        bus.o_regWriteEn = 1'b1;
        retire           = 1'b1;
        nextState        = S_FETCH;
      end
      S_BRANCH: begin
        bus.o_aluSrcA           = 2'b10;
        bus.o_aluLogicOperation = ALU_SUB;
        bus.o_pcWriteEn = bus.i_funct3[0] ? !bus.i_zeroFlag
                                          : bus.i_zeroFlag;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_JAL: begin
        bus.o_aluSrcA   = 2'b01;
        bus.o_aluSrcB   = 2'b10;
        bus.o_pcWriteEn = 1'b1;
        nextState       = S_ALUWB;
      end
      S_TRAP: nextState = S_TRAP;
      default: nextState = S_FETCH;
    endcase
  end

  assign bus.o_illegal      = illegalQ;
  assign bus.o_retiredCount = count;

endmodule
